jtag_ir_dr_path: RTL and testbench

Instruction-register and data-register datapath for the JTAG port, directly downstream of the TAP controller state machine. It consumes the controller's 4-bit state code and TDI, and implements four pieces of logic: the instruction register, a 1-bit BYPASS register, a 32-bit IDCODE register and a DR_W-bit USER data register. It drives TDO and exposes the decoded instruction and the user data to the core. All capture, shift and update actions are taken in the cycle where the corresponding TAP state is present.

---
 rtl/jtag_ir_dr_path.sv | 117 +++++++++++
 tb/tb_jtag_ir_dr_path.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction/data register datapath driven by the TAP controller state code.
// Holds IR, BYPASS, IDCODE and USER registers and muxes the selected LSB onto TDO.
module jtag_ir_dr_path #(
  parameter int unsigned IR_W       = 4,
  parameter int unsigned DR_W       = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic            clk,
  input  logic            TRST,
  input  logic [3:0]      tap_state,
  input  logic            TDI,
  output logic            TDO,
  output logic            tdo_en,
  output logic [IR_W-1:0] ir_out,
  output logic [DR_W-1:0] user_dr,
  output logic            user_upd
);

  localparam logic [3:0] S_TLR   = 4'h0;
  localparam logic [3:0] S_CAPDR = 4'h3;
  localparam logic [3:0] S_SHDR  = 4'h4;
  localparam logic [3:0] S_UPDDR = 4'h8;
  localparam logic [3:0] S_CAPIR = 4'hA;
  localparam logic [3:0] S_SHIR  = 4'hB;
  localparam logic [3:0] S_UPDIR = 4'hF;

  localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] IR_USER   = IR_W'(2);

  logic [IR_W-1:0] r_ir_sh;
  logic [IR_W-1:0] r_ir_out;
  logic            r_byp;
  logic [31:0]     r_id_sh;
  logic [DR_W-1:0] r_usr_sh;
  logic [DR_W-1:0] r_user_dr;
  logic            r_user_upd;

  logic            w_sel_id;
  logic            w_sel_usr;
  logic            w_sel_byp;
  logic [DR_W-1:0] w_usr_shift;

  // Any code other than IDCODE or USER falls through to BYPASS.
  assign w_sel_id    = (r_ir_out == IR_IDCODE);
  assign w_sel_usr   = (r_ir_out == IR_USER);
  assign w_sel_byp   = !(w_sel_id || w_sel_usr);
  assign w_usr_shift = DR_W'({TDI, r_usr_sh} >> 1);

  // Instruction shift and active-instruction registers.
  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      r_ir_sh  <= '0;
      r_ir_out <= IR_IDCODE;
    end else if (tap_state == S_TLR) begin
      r_ir_sh  <= '0;
      r_ir_out <= IR_IDCODE;
    end else begin
      case (tap_state)
        S_CAPIR: r_ir_sh  <= IR_W'(1);
        S_SHIR:  r_ir_sh  <= {TDI, r_ir_sh[IR_W-1:1]};
        S_UPDIR: r_ir_out <= r_ir_sh;
        default: ;
      endcase
    end
  end

  // Data registers; only the register selected by ir_out captures or shifts.
  always_ff @(posedge clk or posedge TRST) begin
    if (TRST) begin
      r_byp      <= 1'b0;
      r_id_sh    <= '0;
      r_usr_sh   <= '0;
      r_user_dr  <= '0;
      r_user_upd <= 1'b0;
    end else if (tap_state == S_TLR) begin
      r_byp      <= 1'b0;
      r_id_sh    <= '0;
      r_usr_sh   <= '0;
      r_user_dr  <= '0;
      r_user_upd <= 1'b0;
    end else begin
      r_user_upd <= (tap_state == S_UPDDR) && w_sel_usr;
      case (tap_state)
        S_CAPDR: begin
          if (w_sel_byp) r_byp    <= 1'b0;
          if (w_sel_id)  r_id_sh  <= IDCODE_VAL;
          if (w_sel_usr) r_usr_sh <= r_user_dr;
        end
        S_SHDR: begin
          if (w_sel_byp) r_byp    <= TDI;
          if (w_sel_id)  r_id_sh  <= {TDI, r_id_sh[31:1]};
          if (w_sel_usr) r_usr_sh <= w_usr_shift;
        end
        S_UPDDR: begin
          if (w_sel_usr) r_user_dr <= r_usr_sh;
        end
        default: ;
      endcase
    end
  end

  // TDO is the pre-edge LSB of whichever register is shifting.
  always_comb begin
    TDO = 1'b0;
    case (tap_state)
      S_SHIR: TDO = r_ir_sh[0];
      S_SHDR: TDO = w_sel_id ? r_id_sh[0] : (w_sel_usr ? r_usr_sh[0] : r_byp);
      default: ;
    endcase
  end

  assign tdo_en   = (tap_state == S_SHIR) || (tap_state == S_SHDR);
  assign ir_out   = r_ir_out;
  assign user_dr  = r_user_dr;
  assign user_upd = r_user_upd;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Scoreboard bench for jtag_ir_dr_path: driver pushes expected TDO bits and USER
// update values from a behavioural model; a negedge monitor pops and compares.
module tb_jtag_ir_dr_path;

  localparam int unsigned IR_W = 4;
  localparam int unsigned DR_W = 8;
  localparam logic [31:0] IDV  = 32'h1000_0001;

  localparam logic [3:0] TLR = 4'h0, RTI = 4'h1, SELDR = 4'h2, CAPDR = 4'h3;
  localparam logic [3:0] SHDR = 4'h4, EX1DR = 4'h5, PAUSEDR = 4'h6, EX2DR = 4'h7;
  localparam logic [3:0] UPDDR = 4'h8, SELIR = 4'h9, CAPIR = 4'hA, SHIR = 4'hB;
  localparam logic [3:0] EX1IR = 4'hC, UPDIR = 4'hF;

  logic            clk = 1'b0;
  logic            TRST = 1'b1;
  logic [3:0]      tap_state = TLR;
  logic            TDI = 1'b0;
  logic            TDO;
  logic            tdo_en;
  logic [IR_W-1:0] ir_out;
  logic [DR_W-1:0] user_dr;
  logic            user_upd;

  jtag_ir_dr_path #(.IR_W(IR_W), .DR_W(DR_W), .IDCODE_VAL(IDV)) dut (
    .clk(clk), .TRST(TRST), .tap_state(tap_state), .TDI(TDI), .TDO(TDO),
    .tdo_en(tdo_en), .ir_out(ir_out), .user_dr(user_dr), .user_upd(user_upd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on   = 1'b0;
  bit mon_skip = 1'b0;
  logic            q_tdo[$];
  logic [DR_W-1:0] q_upd[$];

  // Reference model state.
  logic [IR_W-1:0] m_ir_sh, m_ir_out;
  logic            m_byp;
  logic [31:0]     m_id;
  logic [DR_W-1:0] m_usr, m_user_dr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ir_sh = '0; m_ir_out = IR_W'(1); m_byp = 1'b0;
    m_id = '0; m_usr = '0; m_user_dr = '0;
  endtask

  // One TCK cycle in state st: predict this cycle's TDO, then advance the model at the edge.
  task automatic step(input logic [3:0] st, input logic tdi);
    int sel;
    sel = (m_ir_out == IR_W'(1)) ? 1 : ((m_ir_out == IR_W'(2)) ? 2 : 0);
    tap_state = st;
    TDI = tdi;
    if (st == SHIR) q_tdo.push_back(m_ir_sh[0]);
    if (st == SHDR) q_tdo.push_back(sel == 1 ? m_id[0] : (sel == 2 ? m_usr[0] : m_byp));
    @(posedge clk);
    case (st)
      TLR:   m_reset();
      CAPIR: m_ir_sh = IR_W'(1);
      SHIR:  m_ir_sh = IR_W'((m_ir_sh >> 1) + (IR_W'(tdi) << (IR_W - 1)));
      UPDIR: m_ir_out = m_ir_sh;
      CAPDR: begin
        if (sel == 1) m_id = IDV;
        else if (sel == 2) m_usr = m_user_dr;
        else m_byp = 1'b0;
      end
      SHDR: begin
        if (sel == 1) m_id = (m_id >> 1) + (32'(tdi) << 31);
        else if (sel == 2) m_usr = DR_W'((m_usr >> 1) + (DR_W'(tdi) << (DR_W - 1)));
        else m_byp = tdi;
      end
      UPDDR: begin
        if (sel == 2) begin
          m_user_dr = m_usr;
          q_upd.push_back(m_usr);
        end
      end
      default: ;
    endcase
    #1;
  endtask

  task automatic load_ir(input logic [IR_W-1:0] v);
    step(SELDR, 1'b0);
    step(SELIR, 1'b0);
    step(CAPIR, 1'b0);
    for (int i = 0; i < int'(IR_W); i++) step(SHIR, v[i]);
    step(EX1IR, 1'b0);
    step(UPDIR, 1'b0);
    step(RTI, 1'b0);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] data, input int pause_at, input int plen);
    step(SELDR, 1'b0);
    step(CAPDR, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        step(EX1DR, 1'b0);
        for (int p = 0; p < plen; p++) step(PAUSEDR, 1'($urandom_range(0, 1)));
        step(EX2DR, 1'b0);
      end
      step(SHDR, data[i]);
    end
    step(EX1DR, 1'b0);
    step(UPDDR, 1'b0);
    step(RTI, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on && !mon_skip && !TRST) begin
      if (tdo_en) begin
        if (q_tdo.size() == 0) chk("tdo_en_unexpected", 32'(tdo_en), 32'd0);
        else chk("tdo", 32'(TDO), 32'(q_tdo.pop_front()));
      end else begin
        chk("tdo_idle", 32'(TDO), 32'd0);
      end
      if (user_upd) begin
        if (q_upd.size() == 0) chk("user_upd_unexpected", 32'(user_upd), 32'd0);
        else chk("user_upd_value", 32'(user_dr), 32'(q_upd.pop_front()));
      end
      chk("ir_out", 32'(ir_out), 32'(m_ir_out));
      chk("user_dr", 32'(user_dr), 32'(m_user_dr));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdo", 32'(TDO), 32'd0);
    chk("rst_tdo_en", 32'(tdo_en), 32'd0);
    chk("rst_ir_out", 32'(ir_out), 32'd1);
    chk("rst_user_dr", 32'(user_dr), 32'd0);
    chk("rst_user_upd", 32'(user_upd), 32'd0);
    TRST = 1'b0;
    mon_on = 1'b1;
    step(TLR, 1'b0);
    step(RTI, 1'b0);

    // IDCODE read-out, LSB first.
    dr_scan(32, 64'd0, -1, 0);

    // IR all ones -> BYPASS; capture/shift echoes TDI one cycle late.
    load_ir(4'hF);
    chk("ir_bypass", 32'(ir_out), 32'hF);
    dr_scan(6, {$urandom, $urandom}, -1, 0);

    // USER write and read-back.
    load_ir(4'h2);
    dr_scan(8, 64'hA5, -1, 0);
    chk("user_a5", 32'(user_dr), 32'hA5);
    dr_scan(8, {$urandom, $urandom}, -1, 0);

    // Unlisted code behaves as BYPASS; USER shift register left untouched.
    load_ir(4'h7);
    dr_scan(10, {$urandom, $urandom}, -1, 0);
    load_ir(4'h2);
    step(SELDR, 1'b0);
    for (int i = 0; i < int'(DR_W); i++) step(SHDR, 1'b0);
    step(EX1DR, 1'b0);
    step(RTI, 1'b0);

    // Pause mid-shift, then zero-shift capture/update.
    load_ir(4'h2);
    dr_scan(8, 64'h3C, 4, 5);
    chk("user_pause", 32'(user_dr), 32'h3C);
    dr_scan(0, 64'd0, -1, 0);
    chk("user_zero_shift", 32'(user_dr), 32'h3C);

    // Asynchronous TRST in the middle of a USER shift.
    step(SELDR, 1'b0);
    step(CAPDR, 1'b0);
    repeat (3) step(SHDR, 1'b1);
    mon_skip = 1'b1;
    #2 TRST = 1'b1;
    #1;
    chk("trst_tdo", 32'(TDO), 32'd0);
    chk("trst_ir_out", 32'(ir_out), 32'd1);
    chk("trst_user_dr", 32'(user_dr), 32'd0);
    m_reset();
    tap_state = RTI;
    TRST = 1'b0;
    @(posedge clk);
    #1 mon_skip = 1'b0;
    step(UPDIR, 1'b0);
    chk("upd_after_trst", 32'(ir_out), 32'd0);

    // TLR with TRST low resets identically.
    load_ir(4'h2);
    dr_scan(8, 64'h5A, -1, 0);
    step(TLR, 1'b0);
    chk("tlr_tdo", 32'(TDO), 32'd0);
    chk("tlr_ir_out", 32'(ir_out), 32'd1);
    chk("tlr_user_dr", 32'(user_dr), 32'd0);
    step(RTI, 1'b0);

    // Randomized scans and raw state sequences.
    repeat (120) begin
      int r, n;
      logic [IR_W-1:0] v;
      r = $urandom_range(0, 3);
      v = (r == 0) ? IR_W'(1) : (r == 1) ? IR_W'(2) : (r == 2) ? IR_W'(15) : IR_W'($urandom);
      load_ir(v);
      n = $urandom_range(0, 40);
      dr_scan(n, {$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1,
              int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 6)) step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        step(RTI, 1'b0);
      end
    end

    step(RTI, 1'b0);
    step(RTI, 1'b0);
    chk("q_tdo_drained", 32'(q_tdo.size()), 32'd0);
    chk("q_upd_drained", 32'(q_upd.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
